// File: rtl/temp_calc_pkg.sv
// Shared types and width helpers for the calibrated temperature calculator family.
package temp_calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        HOLD
    } state_e;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned prod_width(input int unsigned coef_w,
                                               input int unsigned sensor_w);
        return coef_w + sensor_w;
    endfunction

    function automatic int unsigned sum_width(input int unsigned base_w,
                                              input int unsigned coef_w,
                                              input int unsigned sensor_w,
                                              input int unsigned frac_bits);
        int unsigned q;
        q = coef_w + sensor_w - frac_bits;
        return ((base_w > q) ? base_w : q) + 1;
    endfunction

    function automatic longint unsigned sat_value(input int unsigned out_w);
        return (64'd1 << out_w) - 64'd1;
    endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, B_W cycles per product.
module seq_shift_add_mul
    import temp_calc_pkg::*;
#(
    parameter int unsigned A_W = 4,
    parameter int unsigned B_W = 4,
    localparam int unsigned P_W = prod_width(A_W, B_W),
    localparam int unsigned CNT_W = idx_width(B_W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] product
);

    logic [A_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             last;

    // done marks the final iteration; product is complete after this edge.
    assign last    = busy_q && (cnt_q == CNT_W'(B_W - 1));
    assign busy    = busy_q;
    assign done    = last;
    assign product = acc_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start && !busy_q) begin
            a_d    = a;
            b_d    = b;
            acc_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (b_q[cnt_q]) begin
                acc_d = acc_q + (P_W'(a_q) << cnt_q);
            end
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/temp_calc_multichannel.sv
// Multi-channel calibrated temperature calculator: per-channel base/coef registers,
// sequential multiply, add and saturate, valid/ready on both sides.
module temp_calc_multichannel
    import temp_calc_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned BASE_W    = 5,
    parameter int unsigned COEF_W    = 4,
    parameter int unsigned SENSOR_W  = 4,
    parameter int unsigned FRAC_BITS = 3,
    parameter int unsigned OUT_W     = 8,
    localparam int unsigned CH_W     = idx_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [BASE_W-1:0]   cfg_base,
    input  logic [COEF_W-1:0]   cfg_coef,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [SENSOR_W-1:0] in_sensor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [OUT_W-1:0]    out_temp,
    output logic                out_sat,
    output logic                out_err
);

    localparam int unsigned PROD_W = prod_width(COEF_W, SENSOR_W);
    localparam int unsigned SUM_W  = sum_width(BASE_W, COEF_W, SENSOR_W, FRAC_BITS);
    localparam int unsigned DEPTH  = 1 << CH_W;
    localparam logic [OUT_W-1:0] SAT_TEMP = OUT_W'(sat_value(OUT_W));

    // Unused upper entries (when NUM_CH is not a power of two) are never written and read as 0.
    logic [BASE_W-1:0] base_mem_q [DEPTH];
    logic [COEF_W-1:0] coef_mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [OUT_W-1:0]  out_temp_q, out_temp_d;
    logic              out_sat_q, out_sat_d;
    logic              out_err_q, out_err_d;

    logic              accept;
    logic              mul_busy;
    logic              mul_done;
    logic [PROD_W-1:0] product;
    logic [SUM_W-1:0]  sum;

    assign in_ready  = rst_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign sum       = SUM_W'(base_q) + SUM_W'(product >> FRAC_BITS);
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_temp  = out_temp_q;
    assign out_sat   = out_sat_q;
    assign out_err   = out_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                base_mem_q[i] <= '0;
                coef_mem_q[i] <= '0;
            end
        end else if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
            base_mem_q[cfg_ch] <= cfg_base;
            coef_mem_q[cfg_ch] <= cfg_coef;
        end
    end

    seq_shift_add_mul #(
        .A_W (COEF_W),
        .B_W (SENSOR_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .a       (coef_mem_q[in_ch]),
        .b       (in_sensor),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        base_d      = base_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_temp_d  = out_temp_q;
        out_sat_d   = out_sat_q;
        out_err_d   = out_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ch_d    = in_ch;
                    base_d  = base_mem_q[in_ch];
                    state_d = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                out_valid_d = 1'b1;
                out_ch_d    = ch_q;
                if (32'(ch_q) >= NUM_CH) begin
                    out_temp_d = '0;
                    out_sat_d  = 1'b0;
                    out_err_d  = 1'b1;
                end else if (|(sum >> OUT_W)) begin
                    out_temp_d = SAT_TEMP;
                    out_sat_d  = 1'b1;
                    out_err_d  = 1'b0;
                end else begin
                    out_temp_d = OUT_W'(sum);
                    out_sat_d  = 1'b0;
                    out_err_d  = 1'b0;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            base_q      <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_temp_q  <= '0;
            out_sat_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            base_q      <= base_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_temp_q  <= out_temp_d;
            out_sat_q   <= out_sat_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule

// File: doc/temp_calc_multichannel.md
Name: temp_calc_multichannel

Overview:
Parametrised, sequential successor to the combinational single-sensor temperature calculator. Holds per-channel calibration registers (base temperature, coefficient) for NUM_CH sensors. For each accepted request it computes temperature = base + ((coef * sensor) >> FRAC_BITS) using a shift-add multiplier, then saturates to OUT_W. Sits between the sensor sampling logic and the display/alarm logic, with valid/ready handshakes on both sides.

Parameters:
NUM_CH, 4, number of sensor channels; CH_W = max(1, clog2(NUM_CH))
BASE_W, 5, width of the factory base temperature
COEF_W, 4, width of the factory temperature coefficient
SENSOR_W, 4, width of the raw sensor value; also the multiplier iteration count
FRAC_BITS, 3, fractional bits dropped from the product (right shift)
OUT_W, 8, width of the temperature output

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  calibration write strobe
cfg_ch  in  CH_W  channel to write
cfg_base  in  BASE_W  base temperature to store
cfg_coef  in  COEF_W  coefficient to store
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_ch  in  CH_W  request channel
in_sensor  in  SENSOR_W  raw sensor value
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_ch  out  CH_W  channel of the result
out_temp  out  OUT_W  calculated temperature
out_sat  out  1  result was clamped to 2^OUT_W-1
out_err  out  1  request channel was >= NUM_CH

Behaviour:
- Reset (async, rst_n=0): state IDLE; all calibration registers cleared to 0; out_valid=0, out_temp=0, out_ch=0, out_sat=0, out_err=0; in_ready=0 while rst_n=0. Reset mid-computation discards the in-flight result and produces no output.
- Clock and reset: single clock; reset is asynchronous and active-low.
- Calibration: when cfg_we=1 and cfg_ch<NUM_CH, regs[cfg_ch] update at the clock edge. Writes with cfg_ch>=NUM_CH are ignored. Writes are allowed in any state.
- FSM states: IDLE, MUL, ADD, HOLD.
- IDLE: in_ready=1. When in_valid=1, the request is accepted. The block latches in_sensor and in_ch, snapshots the base and coef of that channel (pre-write value if cfg_we targets the same channel in the same cycle), clears the accumulator, sets count=0, and moves to MUL.
- MUL: one sensor bit per cycle. If sensor[count]=1, acc += coef << count; then count++. After SENSOR_W cycles, move to ADD. The accumulator width is COEF_W+SENSOR_W, so no overflow is possible.
- ADD: sum = base + (acc >> FRAC_BITS), computed at width max(BASE_W, COEF_W+SENSOR_W-FRAC_BITS)+1.
  - If sum > 2^OUT_W-1: out_temp = all ones, out_sat=1. Otherwise out_temp = sum and out_sat=0.
  - If the channel was >= NUM_CH: out_temp=0, out_sat=0, out_err=1.
  - Register the outputs, set out_valid=1, and move to HOLD.
- HOLD: out_valid and all out_* stay stable until out_ready=1. On that edge out_valid drops to 0 and the state returns to IDLE. in_ready=0 in every state except IDLE.
- Latency: request accepted at edge t gives out_valid=1 after edge t+SENSOR_W+1. Minimum issue interval is SENSOR_W+3 cycles when out_ready is held at 1.
- Config changes after acceptance never affect an in-flight result.

Decomposition:
- Package temp_calc_pkg holds:
  - the state enum (IDLE, MUL, ADD, HOLD);
  - width helper functions: CH_W, product width, sum width;
  - the saturation constant.
- Sub-module seq_shift_add_mul has ports start, a (COEF_W), b (SENSOR_W), busy, done and product. It is reused by later calibrated-sensor blocks. The top module holds the calibration register file, the FSM, the add/saturate stage and the handshakes.

Test Plan:
- Defaults: write ch2 base=20 coef=13; request ch2 sensor=11 -> out_temp=37 (143>>3=17, plus 20), out_sat=0, out_ch=2, out_valid exactly 5 cycles after the accepting edge.
- Same-cycle config write to ch1 (base=31, coef=15) plus request on ch1 with sensor=15, old regs base=5 coef=2 -> uses old values: out_temp=5+(30>>3)=8; next request on ch1 with sensor=15 -> 31+(225>>3)=59.
- Variant params COEF_W=8, SENSOR_W=8, OUT_W=8: base=31, coef=255, sensor=255 -> sum 8159 clamps to out_temp=255, out_sat=1.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and data stable, in_ready=0, in_valid requests not accepted; release -> single transfer, then in_ready=1 in the next cycle.
- Reset mid-MUL: pull rst_n low during count=2 -> out_valid=0 immediately, calibration regs read back as 0 (request sensor=15 on any channel -> out_temp=0), no stale result after release.
- NUM_CH=3 with request ch=3 -> out_err=1, out_temp=0; cfg write to ch=3 has no effect on channels 0-2.
